// File: rtl/mem_ahb_lsu.sv
// mem_ahb_lsu: AHB-Lite manager acting as the MEM-stage load/store unit.
// It accepts one load/store request at a time and runs it as a single AHB
// transfer, honouring slave wait states and two-cycle ERROR responses.
//
// Ports:
//   clk_i, rst_ni            clock (rising edge), asynchronous active-low reset
//   req_valid_i/req_ready_o  request handshake (ready only while idle)
//   req_write_i, req_addr_i, req_wdata_i, req_size_i, req_unsign_i
//                            request attributes (store data right-aligned)
//   resp_valid_o             one-cycle completion pulse
//   resp_rdata_o             extended load data (0 for stores and errors)
//   resp_err_o               completion carries an error
//   stall_o                  pipeline hold while a transfer is outstanding
//   HADDR..HWDATA            AHB-Lite manager outputs
//   HRDATA, HREADY, HRESP    AHB-Lite manager inputs
//
// Optional build macro: MISALIGN_TRAP_EN
//   defined     - misaligned half/word/dword requests are not issued and
//                 complete one cycle later with resp_err_o=1
//   not defined - misaligned addresses are aligned down and issued normally
module mem_ahb_lsu #(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter logic [3:0]  HPROT_VAL  = 4'b0011
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_unsign_i,
    output logic                  resp_valid_o,
    output logic [DATA_WIDTH-1:0] resp_rdata_o,
    output logic                  resp_err_o,
    output logic                  stall_o,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic [1:0]            HTRANS,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic [DATA_WIDTH-1:0] HWDATA,
    input  logic [DATA_WIDTH-1:0] HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP
);

    localparam int NB  = DATA_WIDTH / 8;
    localparam int OFS = $clog2(NB);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_ERR} state_t;

    state_t state;
    logic   unsign_q;
    logic   illegal_size;
    logic   misaligned;
    logic   trap;

    // Clear the low address bits covered by the transfer size.
    function automatic logic [ADDR_WIDTH-1:0] align_addr(
        input logic [ADDR_WIDTH-1:0] a, input logic [1:0] sz);
        logic [ADDR_WIDTH-1:0] mask;
        mask = '1;
        mask = mask << sz;
        return a & mask;
    endfunction

    // Copy the low 2^sz bytes of the store data into every byte lane.
    function automatic logic [DATA_WIDTH-1:0] replicate(
        input logic [DATA_WIDTH-1:0] wd, input logic [1:0] sz);
        logic [DATA_WIDTH-1:0] r;
        int lanes;
        lanes = 1 << sz;
        r = '0;
        for (int i = 0; i < NB; i++) begin
            r[i*8 +: 8] = wd[(i % lanes)*8 +: 8];
        end
        return r;
    endfunction

    // Move the addressed lanes down to bit 0, then sign/zero extend.
    function automatic logic [DATA_WIDTH-1:0] extract(
        input logic [DATA_WIDTH-1:0] rd, input logic [OFS-1:0] ofs,
        input logic [1:0] sz, input logic uns);
        logic [DATA_WIDTH-1:0] sh;
        logic [DATA_WIDTH-1:0] r;
        logic sgn;
        int   wb;
        sh = rd >> (int'(ofs) * 8);
        case (sz)
            2'd0:    begin wb = 8;          sgn = sh[7];            end
            2'd1:    begin wb = 16;         sgn = sh[15];           end
            2'd2:    begin wb = 32;         sgn = sh[31];           end
            default: begin wb = DATA_WIDTH; sgn = sh[DATA_WIDTH-1]; end
        endcase
        for (int i = 0; i < DATA_WIDTH; i++) begin
            r[i] = (i < wb) ? sh[i] : (sgn & ~uns);
        end
        return r;
    endfunction

    assign illegal_size = (DATA_WIDTH == 32) && (req_size_i == 2'd3);
    assign misaligned   = (req_addr_i != align_addr(req_addr_i, req_size_i));

`ifdef MISALIGN_TRAP_EN
    assign trap = illegal_size | misaligned;
`else
    assign trap = illegal_size;
`endif

    assign HBURST  = 3'b000;
    assign HPROT   = HPROT_VAL;
    assign stall_o = (req_valid_i & ~req_ready_o) | (state != S_IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= S_IDLE;
            req_ready_o  <= 1'b1;
            HTRANS       <= TRANS_IDLE;
            HADDR        <= '0;
            HWRITE       <= 1'b0;
            HSIZE        <= 3'b000;
            HWDATA       <= '0;
            unsign_q     <= 1'b0;
            resp_valid_o <= 1'b0;
            resp_err_o   <= 1'b0;
            resp_rdata_o <= '0;
        end else begin
            resp_valid_o <= 1'b0;
            resp_err_o   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        if (trap) begin
                            // Rejected without touching the bus.
                            resp_valid_o <= 1'b1;
                            resp_err_o   <= 1'b1;
                            resp_rdata_o <= '0;
                        end else begin
                            state       <= S_ADDR;
                            req_ready_o <= 1'b0;
                            HTRANS      <= TRANS_NONSEQ;
                            HADDR       <= align_addr(req_addr_i, req_size_i);
                            HWRITE      <= req_write_i;
                            HSIZE       <= {1'b0, req_size_i};
                            // Write data is prepared early and held through the data phase.
                            HWDATA      <= replicate(req_wdata_i, req_size_i);
                            unsign_q    <= req_unsign_i;
                        end
                    end
                end
                S_ADDR: begin
                    if (HREADY) begin
                        state  <= S_DATA;
                        HTRANS <= TRANS_IDLE;
                    end
                end
                S_DATA: begin
                    if (HRESP) begin
                        if (HREADY) begin
                            // Tolerate a collapsed ERROR response.
                            state        <= S_IDLE;
                            req_ready_o  <= 1'b1;
                            resp_valid_o <= 1'b1;
                            resp_err_o   <= 1'b1;
                            resp_rdata_o <= '0;
                        end else begin
                            state <= S_ERR;
                        end
                    end else if (HREADY) begin
                        state        <= S_IDLE;
                        req_ready_o  <= 1'b1;
                        resp_valid_o <= 1'b1;
                        resp_rdata_o <= HWRITE ? '0 :
                                        extract(HRDATA, HADDR[OFS-1:0], HSIZE[1:0], unsign_q);
                    end
                end
                S_ERR: begin
                    if (HREADY) begin
                        state        <= S_IDLE;
                        req_ready_o  <= 1'b1;
                        resp_valid_o <= 1'b1;
                        resp_err_o   <= 1'b1;
                        resp_rdata_o <= '0;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    req_ready_o <= 1'b1;
                    HTRANS      <= TRANS_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_ahb_lsu.md
Name: mem_ahb_lsu

Overview:
Parametrised AHB-Lite manager used as the load/store unit of the MEM stage. It accepts one load/store request at a time from the pipeline and runs it as a single AHB transfer. It honours slave wait states (HREADY) and two-cycle ERROR responses, and returns sign- or zero-extended load data. It drives a stall to the pipeline while a transfer is outstanding.

Parameters:
ADDR_WIDTH, 32, width of the address bus and HADDR.
DATA_WIDTH, 32, width of the data buses; legal values are 32 and 64. NB = DATA_WIDTH/8 byte lanes; OFS = log2(NB) address offset bits.
HPROT_VAL, 4'b0011, constant HPROT value (data access, privileged).

Ports:
clk_i  in  1  clock, rising edge.
rst_ni  in  1  asynchronous active-low reset.
req_valid_i  in  1  request valid.
req_ready_o  out  1  request accepted this cycle when high together with req_valid_i.
req_write_i  in  1  1 = store, 0 = load.
req_addr_i  in  ADDR_WIDTH  byte address.
req_wdata_i  in  DATA_WIDTH  store data, right-aligned.
req_size_i  in  2  0 = byte, 1 = half, 2 = word, 3 = dword.
req_unsign_i  in  1  load zero-extend when 1, sign-extend when 0.
resp_valid_o  out  1  one-cycle pulse marking completion.
resp_rdata_o  out  DATA_WIDTH  extended load data; 0 for stores and errors.
resp_err_o  out  1  qualifies resp_valid_o: transfer failed.
stall_o  out  1  pipeline hold.
HADDR  out  ADDR_WIDTH  AHB address.
HTRANS  out  2  transfer type: IDLE = 00, NONSEQ = 10.
HWRITE  out  1  AHB write.
HSIZE  out  3  AHB transfer size.
HBURST  out  3  burst type; constant 000 (SINGLE).
HPROT  out  4  protection control; constant HPROT_VAL.
HWDATA  out  DATA_WIDTH  AHB write data.
HRDATA  in  DATA_WIDTH  AHB read data.
HREADY  in  1  transfer done / wait-state control.
HRESP  in  1  0 = OKAY, 1 = ERROR.

Behaviour:
- Clocking: one clock, clk_i. Reset is asynchronous, active-low, on rst_ni.
- Reset values: state IDLE; HTRANS=00; HADDR=0; HWRITE=0; HSIZE=0; HWDATA=0; resp_valid_o=0; resp_err_o=0; resp_rdata_o=0; req_ready_o=1; stall_o=0.
- Reset asserted mid-transfer aborts the transfer immediately: HTRANS=IDLE asynchronously, no response is produced.
- FSM states: IDLE, ADDR, DATA, ERR.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i, capture write/addr/wdata/size/unsign and go to ADDR.
  - Illegal request (size 3 with DATA_WIDTH=32): do not issue on the bus; next cycle pulse resp_valid_o with resp_err_o=1; stay IDLE.
- ADDR:
  - Drive HTRANS=NONSEQ, HADDR, HWRITE, HSIZE={1'b0,size}.
  - HADDR low bits are forced aligned to the transfer size.
  - Hold all of these until an edge with HREADY=1, then go to DATA.
- DATA:
  - HTRANS=IDLE.
  - HWDATA = store data replicated across all lanes (byte ×NB, half ×NB/2, ...).
  - HWDATA is held stable throughout wait states.
  - HREADY=1, HRESP=0: capture the response and go to IDLE.
  - HREADY=0, HRESP=1: go to ERR.
  - HREADY=0, HRESP=0: stay in DATA (wait state).
- ERR: HTRANS=IDLE; on HREADY=1 go to IDLE and flag the error response.
- Response timing:
  - resp_valid_o is registered and pulses one cycle after the data-phase completion edge.
  - Zero-wait latency: accept at cycle N, address phase N+1, data phase N+2, resp_valid_o at N+3.
  - Each wait state adds one cycle.
- Load extraction:
  - Shift HRDATA right by addr[OFS-1:0]*8.
  - Keep the low 8, 16, 32 or 64 bits according to size.
  - Sign- or zero-extend to DATA_WIDTH according to unsign.
- req_ready_o=1 only in IDLE. A request presented in the same cycle as resp_valid_o is accepted (back-to-back requests allowed).
- stall_o = req_valid_i & ~req_ready_o, plus 1 whenever state≠IDLE.
- Address wrap: HADDR is truncated to ADDR_WIDTH; no overflow handling.

Optional Feature:
MISALIGN_TRAP_EN
- Defined:
  - A request with addr[size-1:0]≠0 (half/word/dword) is not issued on the bus.
  - One cycle after acceptance, resp_valid_o=1 and resp_err_o=1; state stays IDLE.
- Not defined: misaligned addresses are silently aligned down and the transfer proceeds normally.

Test Plan:
- Word load, addr 0x100, HRDATA=0xDEADBEEF, HREADY always 1 -> NONSEQ at cycle N+1; resp_valid_o at N+3; rdata=0xDEADBEEF; err=0.
- Signed byte load, addr 0x103, HRDATA=0x80123456 -> rdata=0xFFFFFF80. Same load with unsign=1 -> rdata=0x00000080.
- Half store, addr 0x102, wdata=0x00001234 -> HSIZE=001; HWRITE=1; HWDATA=0x12341234 during the data phase; resp_valid_o with err=0.
- Word load with 2 wait states (HREADY=0 for two data-phase cycles) -> HADDR/HWDATA stable; stall_o=1 throughout; resp_valid_o at N+5.
- Slave ERROR (HRESP=1/HREADY=0, then HRESP=1/HREADY=1) -> HTRANS=IDLE in both cycles; resp_valid_o=1; resp_err_o=1; rdata=0.
- Word load at 0x101:
  - MISALIGN_TRAP_EN defined -> no NONSEQ; err pulse at N+1.
  - Not defined -> HADDR=0x100.
  - Also: rst_ni low during DATA -> HTRANS=00 immediately, no resp_valid_o.
